booth_digit_encoder: RTL

//  Radix-4 Booth encoder that feeds the partial-product selector (Multiplier_4X4).
//  - Accepts a signed multiplier operand and scans it two bits per digit.
//  - Emits one {Shift, Negation, Zero} control triplet per digit over a valid/ready handshake.
//  - Sits between the MAC operand fetch and the partial-product generator and accumulator.

---
 rtl/booth_digit_encoder_pkg.sv | 47 ++++
 rtl/booth_digit_encoder_if.sv | 30 +++
 rtl/booth_digit_encoder_triplet_dec.sv | 19 +
 rtl/booth_digit_encoder.sv | 83 ++++++++
 4 files changed

// File: rtl/booth_digit_encoder_pkg.sv
// Shared definitions for the radix-4 Booth encoder: triplet codes, FSM
// state constants, the control-triplet struct and the reference encoding.
package booth_digit_encoder_pkg;

   // Triplet codes t = {b(2i+1), b(2i), b(2i-1)}
   localparam logic [2:0] T_ZERO_LO = 3'b000;
   localparam logic [2:0] T_POS1_A  = 3'b001;
   localparam logic [2:0] T_POS1_B  = 3'b010;
   localparam logic [2:0] T_POS2    = 3'b011;
   localparam logic [2:0] T_NEG2    = 3'b100;
   localparam logic [2:0] T_NEG1_A  = 3'b101;
   localparam logic [2:0] T_NEG1_B  = 3'b110;
   localparam logic [2:0] T_ZERO_HI = 3'b111;

   // FSM states
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_ENC  = 1'b1;

   typedef struct packed {
      logic shift;
      logic neg;
      logic zero;
   } booth_ctl_t;

   // Booth digit select: zero wins, so shift/neg never accompany zero
   function automatic booth_ctl_t booth_enc(input logic [2:0] t);
      booth_ctl_t c;
      c = '0;
      case (t)
         T_ZERO_LO, T_ZERO_HI: c.zero  = 1'b1;
         T_POS1_A,  T_POS1_B:  c       = '0;
         T_POS2:               c.shift = 1'b1;
         T_NEG2: begin
            c.shift = 1'b1;
            c.neg   = 1'b1;
         end
         T_NEG1_A,  T_NEG1_B:  c.neg   = 1'b1;
         default:              c       = '0;
      endcase
      if (c.zero) begin
         c.shift = 1'b0;
         c.neg   = 1'b0;
      end
      return c;
   endfunction

endpackage

// File: rtl/booth_digit_encoder_if.sv
// Operand-in / triplet-out handshake bundle for the Booth encoder.
interface booth_digit_encoder_if #(
   parameter int WIDTH = 4
);
   localparam int NDIG = WIDTH / 2;
   localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] Multiplier;
   logic             out_valid;
   logic             out_ready;
   logic             Shift;
   logic             Negation;
   logic             Zero;
   logic [IDXW-1:0]  digit_idx;
   logic             last;

   // Encoder side
   modport slave (
      input  in_valid, Multiplier, out_ready,
      output in_ready, out_valid, Shift, Negation, Zero, digit_idx, last
   );

   // Producer / consumer side
   modport master (
      output in_valid, Multiplier, out_ready,
      input  in_ready, out_valid, Shift, Negation, Zero, digit_idx, last
   );
endinterface

// File: rtl/booth_digit_encoder_triplet_dec.sv
// Combinational Booth triplet decoder, mirror of the partial-product selector.
module booth_triplet_dec
   import booth_digit_encoder_pkg::*;
(
   input  logic [2:0] t,
   output logic       shift,
   output logic       neg,
   output logic       zero
);
   booth_ctl_t ctl;

   // Pure lookup of the digit controls for one triplet
   always_comb begin
      ctl   = booth_enc(t);
      shift = ctl.shift;
      neg   = ctl.neg;
      zero  = ctl.zero;
   end
endmodule

// File: rtl/booth_digit_encoder.sv
// Radix-4 Booth encoder: loads a signed multiplier, then emits one
// {Shift,Negation,Zero} triplet per digit, LSB digit first.
module booth_digit_encoder
   import booth_digit_encoder_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   booth_digit_encoder_if.slave bus
);
   localparam int NDIG = WIDTH / 2;
   localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

   logic [0:0]      state_q, state_d;
   logic [WIDTH:0]  sr_q, sr_d;     // {operand, b(-1)}; low 3 bits are the current triplet
   logic [IDXW-1:0] idx_q, idx_d;

   logic enc, is_last;
   logic dec_shift, dec_neg, dec_zero;

   assign enc     = (state_q == ST_ENC);
   assign is_last = enc && (idx_q == LAST_IDX);

   booth_triplet_dec u_dec (
      .t     (sr_q[2:0]),
      .shift (dec_shift),
      .neg   (dec_neg),
      .zero  (dec_zero)
   );

   // Next-state: load in IDLE, step two bits per accepted digit in ENC
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               sr_d    = {bus.Multiplier, 1'b0};
               idx_d   = '0;
               state_d = ST_ENC;
            end
         end
         ST_ENC: begin
            if (bus.out_ready) begin
               if (is_last) begin
                  state_d = ST_IDLE;
               end else begin
                  // Arithmetic shift keeps the sign bit feeding upper triplets
                  sr_d  = {sr_q[WIDTH], sr_q[WIDTH], sr_q[WIDTH:2]};
                  idx_d = idx_q + IDXW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         idx_q   <= idx_d;
      end
   end

   // Outputs come from registered state only; everything is zero in IDLE
   assign bus.in_ready  = ~enc;
   assign bus.out_valid = enc;
   assign bus.Shift     = enc & dec_shift;
   assign bus.Negation  = enc & dec_neg;
   assign bus.Zero      = enc & dec_zero;
   assign bus.digit_idx = enc ? idx_q : '0;
   assign bus.last      = is_last;

endmodule
